uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_parity_calc.sv | 15 +
 rtl/uart_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver:
// the frame FSM state encoding and the parity-type selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of a captured UART word: XOR of all bits for even parity,
// inverted for odd parity.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_TYPE   = PAR_EVEN
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  par
);

  assign par = (^data) ^ (PAR_TYPE == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_HOLD_REG_EN to add a one-entry holding register for gapless frames.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (0) on the line
// DATA   | data bit idx on the line, LSB first
// PARITY | parity bit on the line (PAR_EN=1 only)
// STOP   | stop bit (1); may chain straight into START
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 16,
  parameter int PAR_EN     = 0,
  parameter int PAR_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  TX_OUT
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_q, tx_d;
  logic                  par_bit;
  logic                  accept, bit_end, stop_end;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_data;

  assign BUSY     = (state_q != ST_IDLE);
  assign accept   = DATA_VALID && READY;
  assign bit_end  = (cnt_q == CW'(N - 1));
  assign stop_end = (state_q == ST_STOP) && bit_end;
  assign TX_OUT   = tx_q;

`ifdef UART_TX_HOLD_REG_EN
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid;

  assign READY = !hold_valid;
  // A word accepted on the very last stop-bit edge bypasses the hold register.
  assign pend_valid = hold_valid || (accept && BUSY);
  assign pend_data  = hold_valid ? hold_q : P_DATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (stop_end && hold_valid) begin
      hold_valid <= 1'b0;
    end else if (accept && BUSY && !stop_end) begin
      hold_q     <= P_DATA;
      hold_valid <= 1'b1;
    end
  end
`else
  assign READY      = (state_q == ST_IDLE);
  assign pend_valid = 1'b0;
  assign pend_data  = P_DATA;
`endif

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH),
    .PAR_TYPE  (PAR_TYPE)
  ) u_parity (
    .data(data_q),
    .par (par_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      if ((state_q == ST_IDLE) && accept)
        data_q <= P_DATA;
      else if (stop_end && pend_valid)
        data_q <= pend_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;

    if (state_q != ST_IDLE)
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  if (bit_end) begin
                   state_d = ST_DATA;
                   idx_d   = '0;
                 end
      ST_DATA:   if (bit_end) begin
                   if (idx_q == IW'(DATA_WIDTH - 1)) begin
                     idx_d   = '0;
                     state_d = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
                   end else begin
                     idx_d = idx_q + IW'(1);
                   end
                 end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end) state_d = pend_valid ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Line value is decoded from the next state so TX_OUT comes straight off a flop.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[idx_d];
      ST_PARITY: tx_d = par_bit;
      default:   tx_d = 1'b1;
    endcase
  end

endmodule
